// File: rtl/vpu_operand_fetch.sv
// Operand fetch stage: accepts a decoded vector request, streams per-beat SRAM reads on all
// enabled ports, and returns the operand beats in order through a credit-protected buffer.
module vpu_operand_fetch #(
   parameter int unsigned SRAM_R_PORT_CNT    = 3,
   parameter int unsigned OPERAND_ADDR_WIDTH = 8,
   parameter int unsigned VEC_LEN_LG2        = 5,
   parameter int unsigned DATA_WIDTH         = 32,
   parameter int unsigned SRAM_RD_LAT        = 1,
   parameter int unsigned OBUF_DEPTH         = 4
) (
   input  logic                                                   clk,
   input  logic                                                   rst_n,
   input  logic                                                   req_valid_i,
   input  logic [SRAM_R_PORT_CNT-1:0]                             req_rvalid_i,
   input  logic [SRAM_R_PORT_CNT-1:0][OPERAND_ADDR_WIDTH-1:0]     req_raddr_i,
   input  logic [VEC_LEN_LG2-1:0]                                 req_vlen_i,
   input  logic [OPERAND_ADDR_WIDTH-1:0]                          req_waddr_i,
   output logic                                                   rden_o,
   output logic [SRAM_R_PORT_CNT-1:0]                             sram_rden_o,
   output logic [SRAM_R_PORT_CNT-1:0][OPERAND_ADDR_WIDTH-1:0]     sram_raddr_o,
   input  logic [SRAM_R_PORT_CNT-1:0][DATA_WIDTH-1:0]             sram_rdata_i,
   output logic                                                   op_valid_o,
   input  logic                                                   op_ready_i,
   output logic [SRAM_R_PORT_CNT-1:0][DATA_WIDTH-1:0]             op_data_o,
   output logic [OPERAND_ADDR_WIDTH-1:0]                          op_waddr_o,
   output logic                                                   op_last_o
);

   localparam int unsigned PtrW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(OBUF_DEPTH + 1);

   typedef logic [SRAM_R_PORT_CNT-1:0][DATA_WIDTH-1:0] lanes_t;
   typedef enum logic {StIdle, StIssue} state_e;

   state_e                                               state_q;
   logic [SRAM_R_PORT_CNT-1:0]                           mask_q;
   logic [SRAM_R_PORT_CNT-1:0][OPERAND_ADDR_WIDTH-1:0]   raddr_q;
   logic [VEC_LEN_LG2-1:0]                               vlen_q;
   logic [OPERAND_ADDR_WIDTH-1:0]                        waddr_q;
   logic [VEC_LEN_LG2-1:0]                               beat_q;

   logic                                                 pipe_vld_q   [SRAM_RD_LAT];
   logic [OPERAND_ADDR_WIDTH-1:0]                        pipe_waddr_q [SRAM_RD_LAT];
   logic                                                 pipe_last_q  [SRAM_RD_LAT];
   logic [SRAM_R_PORT_CNT-1:0]                           pipe_mask_q  [SRAM_RD_LAT];

   lanes_t                                               obuf_data_q  [OBUF_DEPTH];
   logic [OPERAND_ADDR_WIDTH-1:0]                        obuf_waddr_q [OBUF_DEPTH];
   logic                                                 obuf_last_q  [OBUF_DEPTH];
   logic [PtrW-1:0]                                      wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]                                      count_q, count_d;

   logic                                                 accept, issue, credit_ok;
   logic                                                 push, pop;
   logic [OPERAND_ADDR_WIDTH-1:0]                        beat_ext;
   int unsigned                                          outst;
   lanes_t                                               push_data;

   assign beat_ext = OPERAND_ADDR_WIDTH'(beat_q);

   // Credits cover reads still in flight, so the buffer can never overflow on arrival.
   always_comb begin
      outst = 0;
      for (int k = 0; k < SRAM_RD_LAT; k++) begin
         outst = outst + 32'(pipe_vld_q[k]);
      end
      credit_ok = (outst + 32'(count_q)) < OBUF_DEPTH;
   end

   assign accept = (state_q == StIdle) && req_valid_i;
   assign issue  = (state_q == StIssue) && credit_ok;
   assign rden_o = accept && rst_n;

   always_comb begin
      for (int i = 0; i < SRAM_R_PORT_CNT; i++) begin
         sram_rden_o[i]  = issue && mask_q[i] && rst_n;
         sram_raddr_o[i] = sram_rden_o[i] ? (raddr_q[i] + beat_ext) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         beat_q  <= '0;
         mask_q  <= '0;
         raddr_q <= '0;
         vlen_q  <= '0;
         waddr_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  mask_q  <= req_rvalid_i;
                  raddr_q <= req_raddr_i;
                  vlen_q  <= req_vlen_i;
                  waddr_q <= req_waddr_i;
                  beat_q  <= '0;
                  state_q <= StIssue;
               end
            end
            StIssue: begin
               if (issue) begin
                  beat_q <= beat_q + VEC_LEN_LG2'(1);
                  if (beat_q == vlen_q) state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Token pipeline mirrors the SRAM latency; clearing it on reset drops stale returns.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < SRAM_RD_LAT; k++) begin
            pipe_vld_q[k]   <= 1'b0;
            pipe_waddr_q[k] <= '0;
            pipe_last_q[k]  <= 1'b0;
            pipe_mask_q[k]  <= '0;
         end
      end else begin
         pipe_vld_q[0]   <= issue;
         pipe_waddr_q[0] <= waddr_q + beat_ext;
         pipe_last_q[0]  <= (beat_q == vlen_q);
         pipe_mask_q[0]  <= mask_q;
         for (int k = 1; k < SRAM_RD_LAT; k++) begin
            pipe_vld_q[k]   <= pipe_vld_q[k-1];
            pipe_waddr_q[k] <= pipe_waddr_q[k-1];
            pipe_last_q[k]  <= pipe_last_q[k-1];
            pipe_mask_q[k]  <= pipe_mask_q[k-1];
         end
      end
   end

   assign push = pipe_vld_q[SRAM_RD_LAT-1];
   assign pop  = op_valid_o && op_ready_i;

   always_comb begin
      for (int i = 0; i < SRAM_R_PORT_CNT; i++) begin
         push_data[i] = pipe_mask_q[SRAM_RD_LAT-1][i] ? sram_rdata_i[i] : '0;
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (!push && pop) count_d = count_q - CntW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         obuf_data_q[wr_ptr_q]  <= push_data;
         obuf_waddr_q[wr_ptr_q] <= pipe_waddr_q[SRAM_RD_LAT-1];
         obuf_last_q[wr_ptr_q]  <= pipe_last_q[SRAM_RD_LAT-1];
      end
   end

   assign op_valid_o = rst_n && (count_q != '0);
   assign op_data_o  = op_valid_o ? obuf_data_q[rd_ptr_q] : '0;
   assign op_waddr_o = op_valid_o ? obuf_waddr_q[rd_ptr_q] : '0;
   assign op_last_o  = op_valid_o && obuf_last_q[rd_ptr_q];

endmodule

// File: doc/vpu_operand_fetch.md
VPU_OPERAND_FETCH -- requirements
Module: vpu_operand_fetch

Interface
REQ-001 SHALL have parameter SRAM_R_PORT_CNT, default 3, number of source operand read ports.
REQ-002 SHALL have parameter OPERAND_ADDR_WIDTH, default 8, SRAM bank address width.
REQ-003 SHALL have parameter VEC_LEN_LG2, default 5, width of the vlen field; beats per request = vlen+1.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, SRAM read data width per port.
REQ-005 SHALL have parameter SRAM_RD_LAT, default 1 (legal range 1..3), SRAM read latency in cycles.
REQ-006 SHALL have parameter OBUF_DEPTH, default 4 (power of two), output buffer entries.
REQ-007 clk  in  1  sole clock, all logic on rising edge.
REQ-008 rst_n  in  1  reset, synchronous, active-low.
REQ-009 req_valid_i  in  1  decoder request present (REQ_IF valid).
REQ-010 req_rvalid_i  in  SRAM_R_PORT_CNT  per-port source-operand enable.
REQ-011 req_raddr_i  in  SRAM_R_PORT_CNT x OPERAND_ADDR_WIDTH  per-port start address.
REQ-012 req_vlen_i  in  VEC_LEN_LG2  beat count minus one.
REQ-013 req_waddr_i  in  OPERAND_ADDR_WIDTH  destination start address.
REQ-014 rden_o  out  1  one-cycle pop strobe to the decoder instruction FIFO.
REQ-015 sram_rden_o  out  SRAM_R_PORT_CNT  per-port SRAM read enable.
REQ-016 sram_raddr_o  out  SRAM_R_PORT_CNT x OPERAND_ADDR_WIDTH  per-port SRAM read address.
REQ-017 sram_rdata_i  in  SRAM_R_PORT_CNT x DATA_WIDTH  per-port read data, valid SRAM_RD_LAT cycles after rden.
REQ-018 op_valid_o / op_ready_i  out/in  1/1  operand beat handshake to the execution unit.
REQ-019 op_data_o  out  SRAM_R_PORT_CNT x DATA_WIDTH  operand lanes; op_waddr_o out OPERAND_ADDR_WIDTH; op_last_o out 1.

Function
REQ-020 SHALL implement FSM states IDLE and ISSUE.
REQ-021 IDLE: when req_valid_i=1, SHALL latch rvalid/raddr/vlen/waddr, pulse rden_o for exactly that cycle, clear beat_cnt, enter ISSUE next cycle.
REQ-022 rden_o SHALL never assert outside IDLE and never for two consecutive cycles.
REQ-023 ISSUE: a beat issues in a cycle iff (outstanding reads + obuf occupancy) < OBUF_DEPTH.
REQ-024 On issue, sram_rden_o[i] = latched rvalid[i]; sram_raddr_o[i] = raddr[i] + beat_cnt, modulo 2^OPERAND_ADDR_WIDTH (wrap, no error).
REQ-025 Port with rvalid=0 SHALL keep sram_rden_o[i]=0 and present op_data_o lane i = 0 for that beat.
REQ-026 A request with all rvalid=0 SHALL still produce vlen+1 beats of zero data with waddr/last.
REQ-027 beat_cnt SHALL increment per issued beat; on issuing beat_cnt==vlen, SHALL return to IDLE next cycle.
REQ-028 Back-to-back requests SHALL be accepted in the IDLE cycle directly following the last issue (min 1 IDLE cycle between requests).
REQ-029 A SRAM_RD_LAT-deep shift pipeline SHALL carry {issued, waddr+beat_cnt, last, rvalid mask}; the returned data plus pipeline token are written into obuf on the token's arrival cycle.
REQ-030 obuf SHALL be FIFO order; op_valid_o = obuf not empty; pop on op_valid_o & op_ready_i.
REQ-031 Simultaneous obuf push and pop SHALL keep occupancy unchanged; credit rule of REQ-023 guarantees no overflow.
REQ-032 op_last_o SHALL be 1 exactly on the beat with index vlen.
REQ-033 op outputs SHALL hold stable while op_valid_o=1 and op_ready_i=0.
REQ-034 Maximum throughput SHALL be one beat per cycle when op_ready_i held high.

Reset
REQ-035 On rst_n=0 at a clock edge: FSM=IDLE, beat_cnt=0, obuf empty, read pipeline tokens cleared, outstanding=0.
REQ-036 During and after reset until new activity: rden_o=0, sram_rden_o=0, sram_raddr_o=0, op_valid_o=0, op_data_o=0, op_waddr_o=0, op_last_o=0.
REQ-037 Reset mid-request SHALL abandon it; SRAM data returning after reset SHALL be discarded.

Verification
REQ-038 rvalid=3'b011, raddr={0,0x10,0x20}, vlen=3, waddr=0x40, ready=1 -> rden_o 1 pulse; 4 beats, lane0=mem[0x20..0x23]... per port, lane2=0, waddr 0x40..0x43, last on 4th.
REQ-039 raddr port0=0xFE, vlen=3 -> sram_raddr_o 0xFE,0xFF,0x00,0x01.
REQ-040 vlen=15, op_ready_i=0 for 20 cycles -> exactly OBUF_DEPTH reads issued, then stall; release ready -> 16 in-order beats, no loss/duplication.
REQ-041 Two requests queued, ready=1 -> second rden_o one cycle after first request's last issue; beats contiguous except 1-cycle gap.
REQ-042 Assert rst_n=0 at beat 2 of vlen=7 -> next cycle all outputs 0; no stale op_valid_o after release.
REQ-043 rvalid=0, vlen=0 -> no sram_rden_o, one beat data 0, op_last_o=1.
